// File: rtl/vga_pkg.sv
// Shared VGA constants: active area, background mode encodings and the 12-bit palette.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GREY  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  localparam logic [11:0] C_WHITE   = 12'hFFF;
  localparam logic [11:0] C_YELLOW  = 12'hFF0;
  localparam logic [11:0] C_CYAN    = 12'h0FF;
  localparam logic [11:0] C_GREEN   = 12'h0F0;
  localparam logic [11:0] C_MAGENTA = 12'hF0F;
  localparam logic [11:0] C_RED     = 12'hF00;
  localparam logic [11:0] C_BLUE    = 12'h00F;
  localparam logic [11:0] C_BLACK   = 12'h000;
  localparam logic [11:0] C_GREY    = 12'h888;

  // Colour of bar number idx, counted from the left edge of the screen.
  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    logic [11:0] col;
    case (idx)
      3'd0:    col = C_WHITE;
      3'd1:    col = C_YELLOW;
      3'd2:    col = C_CYAN;
      3'd3:    col = C_GREEN;
      3'd4:    col = C_MAGENTA;
      3'd5:    col = C_RED;
      3'd6:    col = C_BLUE;
      default: col = C_BLACK;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/box_motion_ctrl.sv
// One axis of the bouncing square: position in [0, LIM], reversing at either end.
module box_motion_ctrl
  import vga_pkg::*;
#(
  parameter int LIM   = 608,
  parameter int SPEED = 2,
  parameter int P0    = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_step,
  output logic [11:0] o_pos,
  output logic        o_dir
);

  localparam logic [11:0] L_LIM = 12'(LIM);
  localparam logic [11:0] L_SPD = 12'(SPEED);
  localparam logic [11:0] L_P0  = 12'(P0);

  logic [11:0] r_pos;
  dir_t        r_dir;
  logic [11:0] w_fwd;

  assign w_fwd = r_pos + L_SPD;

  // Advance one step per request, clamping to the end stop and reversing there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos <= L_P0;
      r_dir <= DIR_POS;
    end else if (i_step) begin
      if (r_dir == DIR_POS) begin
        if (w_fwd >= L_LIM) begin
          r_pos <= L_LIM;
          r_dir <= DIR_NEG;
        end else begin
          r_pos <= w_fwd;
        end
      end else begin
        if (r_pos <= L_SPD) begin
          r_pos <= 12'd0;
          r_dir <= DIR_POS;
        end else begin
          r_pos <= r_pos - L_SPD;
        end
      end
    end
  end

  assign o_pos = r_pos;
  assign o_dir = r_dir;

endmodule

// File: rtl/vga_bounce_renderer.sv
// Pixel colour stage: background pattern plus a bouncing square, with sync delayed to match RGB.
module vga_bounce_renderer
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE  = VGA_H_ACTIVE,
  parameter int          V_ACTIVE  = VGA_V_ACTIVE,
  parameter int          BOX_SIZE  = 32,
  parameter int          SPEED     = 2,
  parameter int          BOX_X0    = 100,
  parameter int          BOX_Y0    = 100,
  parameter logic [11:0] BOX_COLOR = 12'hF00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_disp_en,
  input  logic [10:0] i_next_x,
  input  logic [9:0]  i_next_y,
  input  logic [1:0]  i_mode,
  input  logic        i_pause,
  output logic [3:0]  o_red,
  output logic [3:0]  o_green,
  output logic [3:0]  o_blue,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_frame_tick
);

  localparam int          BAR_W = H_ACTIVE / 8;
  localparam logic [11:0] L_BOX = 12'(BOX_SIZE);

  logic        r_vs_prev;
  logic        r_tick;
  mode_t       r_mode;

  logic        r_hs1, r_vs1, r_de1, r_hit1;
  logic [11:0] r_bg1;
  logic        r_hs2, r_vs2;
  logic [11:0] r_rgb;

  logic [11:0] w_box_x, w_box_y;
  logic        w_x_dir, w_y_dir;
  logic [1:0]  w_unused_dirs;
  logic        w_step;
  logic [11:0] w_x, w_y;
  logic        w_hit;
  logic [2:0]  w_bar_idx;
  logic [11:0] w_bg;

  assign w_step        = r_tick & ~i_pause;
  assign w_unused_dirs = {w_x_dir, w_y_dir};

  box_motion_ctrl #(
    .LIM   (H_ACTIVE - BOX_SIZE),
    .SPEED (SPEED),
    .P0    (BOX_X0)
  ) u_x_motion (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_step  (w_step),
    .o_pos   (w_box_x),
    .o_dir   (w_x_dir)
  );

  box_motion_ctrl #(
    .LIM   (V_ACTIVE - BOX_SIZE),
    .SPEED (SPEED),
    .P0    (BOX_Y0)
  ) u_y_motion (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_step  (w_step),
    .o_pos   (w_box_y),
    .o_dir   (w_y_dir)
  );

  // Detect the vs falling edge and latch the background mode once per frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_prev <= 1'b1;
      r_tick    <= 1'b0;
      r_mode    <= MODE_BLACK;
    end else begin
      r_vs_prev <= i_vs;
      r_tick    <= r_vs_prev & ~i_vs;
      if (r_tick) begin
        r_mode <= mode_t'(i_mode);
      end
    end
  end

  assign w_x   = {1'b0, i_next_x};
  assign w_y   = {2'b00, i_next_y};
  assign w_hit = (w_x >= w_box_x) && (w_x < w_box_x + L_BOX) &&
                 (w_y >= w_box_y) && (w_y < w_box_y + L_BOX);

  // Pick the colour-bar index from the x coordinate using threshold compares.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w_x >= 12'(i * BAR_W)) begin
        w_bar_idx = 3'(i);
      end
    end
  end

  // Background colour for the frame's latched mode.
  always_comb begin
    w_bg = C_BLACK;
    case (r_mode)
      MODE_BLACK: w_bg = C_BLACK;
      MODE_BARS:  w_bg = bar_color(w_bar_idx);
      MODE_CHECK: w_bg = (i_next_x[5] ^ i_next_y[5]) ? C_WHITE : C_BLACK;
      MODE_GREY:  w_bg = C_GREY;
      default:    w_bg = C_BLACK;
    endcase
  end

  // Stage 1: register syncs, display enable, box hit and background colour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_de1  <= 1'b0;
      r_hit1 <= 1'b0;
      r_bg1  <= C_BLACK;
    end else begin
      r_hs1  <= i_hs;
      r_vs1  <= i_vs;
      r_de1  <= i_disp_en;
      r_hit1 <= w_hit;
      r_bg1  <= w_bg;
    end
  end

  // Stage 2: final colour with square priority and blanking, plus aligned syncs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
      r_rgb <= C_BLACK;
    end else begin
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      if (!r_de1) begin
        r_rgb <= C_BLACK;
      end else if (r_hit1) begin
        r_rgb <= BOX_COLOR;
      end else begin
        r_rgb <= r_bg1;
      end
    end
  end

  assign {o_red, o_green, o_blue} = r_rgb;
  assign o_hs         = r_hs2;
  assign o_vs         = r_vs2;
  assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Directed bench for vga_bounce_renderer with the square starting near the right edge.
module tb_vga_bounce_renderer;

  localparam int BX0 = 604;
  localparam int BY0 = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        de = 1'b0;
  logic [10:0] nx = '0;
  logic [9:0]  ny = '0;
  logic [1:0]  mode = 2'd0;
  logic        pause = 1'b0;
  logic [3:0]  red, green, blue;
  logic        ohs, ovs, otick;
  logic [11:0] rgb;

  int checks = 0;
  int errors = 0;

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  vga_bounce_renderer #(
    .BOX_X0 (BX0),
    .BOX_Y0 (BY0)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hs         (hs),
    .i_vs         (vs),
    .i_disp_en    (de),
    .i_next_x     (nx),
    .i_next_y     (ny),
    .i_mode       (mode),
    .i_pause      (pause),
    .o_red        (red),
    .o_green      (green),
    .o_blue       (blue),
    .o_hs         (ohs),
    .o_vs         (ovs),
    .o_frame_tick (otick)
  );

  // Present one pixel and return the colour that emerges two cycles later.
  task automatic probe(input int x, input int y, input logic d, output logic [11:0] col);
    @(negedge clk);
    nx = 11'(x); ny = 10'(y); de = d; hs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 col = rgb;
  endtask

  // Produce one vs falling edge; report the tick level on its pulse cycle and the cycle after.
  task automatic do_tick(output logic t_on, output logic t_off);
    @(negedge clk);
    de = 1'b0; vs = 1'b0;
    @(posedge clk);
    #1 t_on = otick;
    @(negedge clk);
    vs = 1'b1;
    @(posedge clk);
    #1 t_off = otick;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nx = 11'(BX0); ny = 10'(BY0); de = 1'b1; hs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rgb !== 12'hF00 || ohs !== 1'b0) begin
      errors++; $display("[TB] FAIL pre_reset_pixel: rgb=%h hs=%b, expected rgb=f00 hs=0", rgb, ohs);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rgb, ohs, ovs, otick} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL reset_async: rgb=%h hs=%b vs=%b tick=%b, expected 000 1 1 0", rgb, ohs, ovs, otick);
    end
    hs = 1'b1; de = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({rgb, ohs, ovs, otick} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
        errors++; $display("[TB] FAIL reset_hold[%0d]: rgb=%h hs=%b vs=%b tick=%b, expected 000 1 1 0", i, rgb, ohs, ovs, otick);
      end
    end
  endtask

  task automatic test_latency();
    logic [11:0] col;
    @(negedge clk);
    nx = 11'(BX0); ny = 10'(BY0); de = 1'b1; hs = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rgb !== 12'h000 || ohs !== 1'b1) begin
      errors++; $display("[TB] FAIL latency_early: rgb=%h hs=%b, expected 000 1", rgb, ohs);
    end
    @(negedge clk);
    hs = 1'b1; de = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rgb !== 12'hF00 || ohs !== 1'b0 || ovs !== 1'b1) begin
      errors++; $display("[TB] FAIL latency_n2: rgb=%h hs=%b vs=%b, expected f00 0 1", rgb, ohs, ovs);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rgb !== 12'h000 || ohs !== 1'b1) begin
      errors++; $display("[TB] FAIL latency_after: rgb=%h hs=%b, expected 000 1", rgb, ohs);
    end
    probe(BX0 - 1, BY0, 1'b1, col);
    checks++;
    if (col !== 12'h000) begin errors++; $display("[TB] FAIL box_left_edge: got %h expected 000", col); end
    probe(BX0 + 31, BY0 + 31, 1'b1, col);
    checks++;
    if (col !== 12'hF00) begin errors++; $display("[TB] FAIL box_corner: got %h expected f00", col); end
    probe(BX0, BY0 - 1, 1'b1, col);
    checks++;
    if (col !== 12'h000) begin errors++; $display("[TB] FAIL box_top_edge: got %h expected 000", col); end
  endtask

  task automatic test_motion();
    int xs[3] = '{606, 608, 606};
    int ys[3] = '{102, 104, 106};
    logic t_on, t_off;
    logic [11:0] col;
    pause = 1'b0; mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      do_tick(t_on, t_off);
      checks++;
      if (t_on !== 1'b1 || t_off !== 1'b0) begin
        errors++; $display("[TB] FAIL motion_tick[%0d]: got %b%b expected 10", i, t_on, t_off);
      end
      probe(xs[i], ys[i], 1'b1, col);
      checks++;
      if (col !== 12'hF00) begin errors++; $display("[TB] FAIL motion_in[%0d]: got %h expected f00", i, col); end
      probe(xs[i] - 1, ys[i], 1'b1, col);
      checks++;
      if (col !== 12'h000) begin errors++; $display("[TB] FAIL motion_xleft[%0d]: got %h expected 000", i, col); end
      probe(xs[i], ys[i] - 1, 1'b1, col);
      checks++;
      if (col !== 12'h000) begin errors++; $display("[TB] FAIL motion_yabove[%0d]: got %h expected 000", i, col); end
    end
  endtask

  task automatic test_pause();
    logic t_on, t_off;
    logic [11:0] col;
    int pulses = 0;
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_tick(t_on, t_off);
      if (t_on === 1'b1 && t_off === 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 2) begin errors++; $display("[TB] FAIL pause_ticks: got %0d expected 2", pulses); end
    probe(606, 106, 1'b1, col);
    checks++;
    if (col !== 12'hF00) begin errors++; $display("[TB] FAIL pause_in: got %h expected f00", col); end
    probe(605, 106, 1'b1, col);
    checks++;
    if (col !== 12'h000) begin errors++; $display("[TB] FAIL pause_left: got %h expected 000", col); end
    probe(638, 137, 1'b1, col);
    checks++;
    if (col !== 12'h000) begin errors++; $display("[TB] FAIL pause_right: got %h expected 000", col); end
  endtask

  task automatic test_bars();
    int          bx[7]   = '{0, 79, 80, 160, 400, 560, 639};
    logic [11:0] bexp[7] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'hF00, 12'h000, 12'h000};
    logic t_on, t_off;
    logic [11:0] col;
    mode = 2'd1;
    do_tick(t_on, t_off);
    for (int i = 0; i < 7; i++) begin
      probe(bx[i], 300, 1'b1, col);
      checks++;
      if (col !== bexp[i]) begin errors++; $display("[TB] FAIL bars_x%0d: got %h expected %h", bx[i], col, bexp[i]); end
    end
    probe(0, 300, 1'b0, col);
    checks++;
    if (col !== 12'h000) begin errors++; $display("[TB] FAIL bars_blank: got %h expected 000", col); end
    probe(620, 120, 1'b1, col);
    checks++;
    if (col !== 12'hF00) begin errors++; $display("[TB] FAIL bars_box_priority: got %h expected f00", col); end
  endtask

  task automatic test_mode_latch();
    int          px[5]   = '{100, 32, 0, 32, 0};
    int          py[5]   = '{0, 0, 0, 32, 32};
    logic [11:0] cexp[5] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF};
    logic t_on, t_off;
    logic [11:0] col;
    mode = 2'd2;
    probe(100, 0, 1'b1, col);
    checks++;
    if (col !== 12'hFF0) begin errors++; $display("[TB] FAIL mode_no_tear: got %h expected ff0", col); end
    do_tick(t_on, t_off);
    for (int i = 0; i < 5; i++) begin
      probe(px[i], py[i], 1'b1, col);
      checks++;
      if (col !== cexp[i]) begin errors++; $display("[TB] FAIL check_%0d_%0d: got %h expected %h", px[i], py[i], col, cexp[i]); end
    end
    mode = 2'd3;
    do_tick(t_on, t_off);
    probe(0, 300, 1'b1, col);
    checks++;
    if (col !== 12'h888) begin errors++; $display("[TB] FAIL grey: got %h expected 888", col); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rgb, ohs, ovs, otick} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL power_on_reset: rgb=%h hs=%b vs=%b tick=%b, expected 000 1 1 0", rgb, ohs, ovs, otick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_latency();
    test_motion();
    test_pause();
    test_bars();
    test_mode_latch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
